// File: rtl/rr_pkt_scheduler.sv
// Three-channel round-robin AXI-Stream packet scheduler. It locks onto one requester per packet.
// An optional stall watchdog is compiled in when the ARB_WATCHDOG_EN macro is defined.
module rr_pkt_scheduler #(
  parameter int P_TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,

  input  logic [63:0] s_axis_c0_data,
  input  logic [79:0] s_axis_c0_user,
  input  logic [7:0]  s_axis_c0_keep,
  input  logic        s_axis_c0_last,
  input  logic        s_axis_c0_valid,
  output logic        s_axis_c0_ready,

  input  logic [63:0] s_axis_c1_data,
  input  logic [79:0] s_axis_c1_user,
  input  logic [7:0]  s_axis_c1_keep,
  input  logic        s_axis_c1_last,
  input  logic        s_axis_c1_valid,
  output logic        s_axis_c1_ready,

  input  logic [63:0] s_axis_c2_data,
  input  logic [79:0] s_axis_c2_user,
  input  logic [7:0]  s_axis_c2_keep,
  input  logic        s_axis_c2_last,
  input  logic        s_axis_c2_valid,
  output logic        s_axis_c2_ready,

  output logic [63:0] m_axis_out_data,
  output logic [79:0] m_axis_out_user,
  output logic [7:0]  m_axis_out_keep,
  output logic        m_axis_out_last,
  output logic        m_axis_out_valid,
  input  logic        m_axis_out_ready,

  output logic [1:0]  o_grant,
  output logic        o_busy,
  output logic        o_timeout
);

  if (P_TIMEOUT < 2 || P_TIMEOUT > 65535) begin : g_bad_timeout
    $error("rr_pkt_scheduler: P_TIMEOUT must be in 2..65535");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] grant_q, grant_d;

  logic [2:0] in_valid;
  logic [1:0] cand0, cand1, cand2;
  logic       sel_found;
  logic [1:0] sel_idx;
  logic       xfer;
  logic       wd_fire;

  function automatic logic [1:0] inc_mod3(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  assign in_valid = {s_axis_c2_valid, s_axis_c1_valid, s_axis_c0_valid};

  // Search order starts at the round-robin pointer and wraps modulo 3.
  assign cand0     = rr_ptr_q;
  assign cand1     = inc_mod3(cand0);
  assign cand2     = inc_mod3(cand1);
  assign sel_found = |in_valid;
  assign sel_idx   = in_valid[cand0] ? cand0 :
                     in_valid[cand1] ? cand1 : cand2;

  // Output mux: zero in IDLE (and therefore in reset), a pass-through of the granted channel in BUSY.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    m_axis_out_data  = '0;
    m_axis_out_user  = '0;
    m_axis_out_keep  = '0;
    m_axis_out_last  = 1'b0;
    m_axis_out_valid = 1'b0;
    s_axis_c0_ready  = 1'b0;
    s_axis_c1_ready  = 1'b0;
    s_axis_c2_ready  = 1'b0;
    if (state_q == ST_BUSY) begin
      case (grant_q)
        2'd0: begin
          m_axis_out_data  = s_axis_c0_data;
          m_axis_out_user  = s_axis_c0_user;
          m_axis_out_keep  = s_axis_c0_keep;
          m_axis_out_last  = s_axis_c0_last;
          m_axis_out_valid = s_axis_c0_valid;
          s_axis_c0_ready  = m_axis_out_ready;
        end
        2'd1: begin
          m_axis_out_data  = s_axis_c1_data;
          m_axis_out_user  = s_axis_c1_user;
          m_axis_out_keep  = s_axis_c1_keep;
          m_axis_out_last  = s_axis_c1_last;
          m_axis_out_valid = s_axis_c1_valid;
          s_axis_c1_ready  = m_axis_out_ready;
        end
        2'd2: begin
          m_axis_out_data  = s_axis_c2_data;
          m_axis_out_user  = s_axis_c2_user;
          m_axis_out_keep  = s_axis_c2_keep;
          m_axis_out_last  = s_axis_c2_last;
          m_axis_out_valid = s_axis_c2_valid;
          s_axis_c2_ready  = m_axis_out_ready;
        end
        default: ;
      endcase
    end
  end

  assign xfer = m_axis_out_valid & m_axis_out_ready;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // The final beat and a watchdog release both end the packet and advance the pointer past this grant.
        if ((xfer && m_axis_out_last) || wd_fire) begin
          state_d  = ST_IDLE;
          rr_ptr_d = inc_mod3(grant_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 2'd0;
      grant_q  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q == ST_BUSY);

`ifdef ARB_WATCHDOG_EN
  localparam logic [15:0] WD_LIMIT = 16'(P_TIMEOUT);

  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;

  // A transfer takes priority over the limit. The count is also held at zero outside BUSY,
  // so every grant starts from a cleared counter.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_fire  = 1'b0;
    if (state_q != ST_BUSY || xfer) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q + 16'd1 == WD_LIMIT) begin
      wd_fire  = 1'b1;
      wd_cnt_d = '0;
    end else begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
    timeout_d = wd_fire;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign wd_fire   = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: doc/rr_pkt_scheduler.md
RR_PKT_SCHEDULER -- requirements
Module: rr_pkt_scheduler

Interface
REQ-001 Parameter P_TIMEOUT, default 1024; idle-cycle limit for the stall watchdog, range 2..65535.
REQ-002 i_clk  in  1  sole clock; all logic on the rising edge.
REQ-003 i_rst  in  1  reset, asynchronous and active-high.
REQ-004 s_axis_cN_data/user/keep/last/valid  in  64/80/8/1/1  requester N stream, for N = 0, 1, 2.
REQ-005 s_axis_cN_ready  out  1  requester N accept, for N = 0, 1, 2.
REQ-006 m_axis_out_data/user/keep/last/valid  out  64/80/8/1/1  merged output stream.
REQ-007 m_axis_out_ready  in  1  downstream accept.
REQ-008 o_grant  out  2  index of the granted channel (0..2); holds its last value when idle.
REQ-009 o_busy  out  1  high while a packet is in flight.
REQ-010 o_timeout  out  1  one-cycle pulse on a watchdog release.

Function
REQ-011 The block SHALL have two states: IDLE and BUSY.
REQ-012 In IDLE, the block SHALL search channels starting at rr_ptr in the order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3), and select the first channel with valid=1.
REQ-013 On a selection, the block SHALL register o_grant and enter BUSY on the next edge; grant latency from first valid to o_busy=1 SHALL be 1 cycle.
REQ-014 In BUSY, m_axis_out_* SHALL combinationally equal the granted channel's inputs.
REQ-015 In BUSY, only the granted channel's ready SHALL equal m_axis_out_ready; all other readys SHALL be 0.
REQ-016 In IDLE, all s_axis_cN_ready and m_axis_out_valid SHALL be 0.
REQ-017 A beat SHALL transfer only when valid and ready are both 1; data, user and keep SHALL pass unmodified.
REQ-018 When a beat with last=1 transfers, the block SHALL return to IDLE and set rr_ptr = (grant+1) mod 3.
REQ-019 The lock SHALL hold for the whole packet; valid on other channels SHALL NOT change the grant mid-packet.
REQ-020 A packet of 1 beat (valid and last on the first beat) SHALL complete in a single BUSY cycle.
REQ-021 Back-to-back packets SHALL have exactly one IDLE cycle between the last beat and the next grant.
REQ-022 When no channel is valid in IDLE, the block SHALL stay in IDLE and leave rr_ptr unchanged.
REQ-023 The user field SHALL be forwarded on every beat; the block SHALL NOT interpret it.

Reset
REQ-024 While i_rst=1, the block SHALL hold: state=IDLE, rr_ptr=0, o_grant=0, o_busy=0, o_timeout=0, watchdog count=0.
REQ-025 While i_rst=1, all readys and m_axis_out_valid SHALL be 0, and m_axis_out_data/user/keep/last SHALL be 0.
REQ-026 An assertion of i_rst mid-packet SHALL abort the packet; downstream sees a truncated stream with no last, and recovering from that is the downstream's responsibility.

Configuration
REQ-027 The watchdog SHALL be included only when macro ARB_WATCHDOG_EN is defined.
REQ-028 Watchdog counter: 16 bits; counts BUSY cycles with no transfer; clears on any transfer or on entering BUSY.
REQ-029 When the count reaches P_TIMEOUT, the block SHALL go to IDLE, pulse o_timeout for 1 cycle, and set rr_ptr = (grant+1) mod 3.
REQ-030 A transfer in the same cycle the count reaches P_TIMEOUT SHALL win: no timeout, and the count clears.
REQ-031 Without ARB_WATCHDOG_EN, BUSY SHALL wait indefinitely, o_timeout SHALL be tied 0, and no counter SHALL be instantiated.

Verification
REQ-032 Channels c0, c1, c2 all valid with 4-beat packets, m_ready=1 -> order c0, c1, c2, c0; o_grant 0, 1, 2, 0; 1 idle cycle between packets.
REQ-033 c1 sends 8 beats; c0 raises valid at beat 3 -> c1's packet completes uninterrupted; c0 granted 2 cycles after c1's last beat.
REQ-034 m_ready toggles 1/0 each cycle during a 5-beat c2 packet -> 5 transfers over 10 cycles; c2 ready equals m_ready; data matches input in order.
REQ-035 Single-beat packet on c0 with keep=8'h0F -> one BUSY cycle; out last=1, keep=8'h0F; rr_ptr becomes 1.
REQ-036 ARB_WATCHDOG_EN, P_TIMEOUT=4; c1 granted, then valid drops mid-packet -> o_timeout pulses after 4 stall cycles; next grant starts search at c2.
REQ-037 i_rst asserted at beat 2 of a c0 packet -> all outputs 0 immediately; after release, c0 is re-granted first since rr_ptr=0.
